apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
// - Shares one APB4 master port among NUM_REQ on-chip requesters (UVM-side drivers, register sequencers).
// - Round-robin arbitration; drives the APB SETUP/ACCESS sequence and routes the response to the winner.
// - Sits between the requester fabric and the ifApbMaster signal bundle; one transfer outstanding at a time.
// PARAMETERS
// - NUM_REQ      4   number of requesters, 2..8
// - ADDR_W       32  paddr width
// - DATA_W       32  pwdata/prdata width; pstrb width = DATA_W/8
// - TIMEOUT_CYC  256 ACCESS-phase wait limit (used only with APB_ARB_TIMEOUT_EN)
// PORTS
// - pclk       in   1               APB clock, single clock domain
// - preset_n   in   1               asynchronous active-low reset
// - req_valid  in   NUM_REQ         request pending, held until req_ready
// - req_ready  out  NUM_REQ         one-cycle grant pulse; request captured
// - req_write  in   NUM_REQ         1=write, 0=read
// - req_addr   in   NUM_REQ*ADDR_W  flattened, requester i at [i*ADDR_W +: ADDR_W]
// - req_wdata  in   NUM_REQ*DATA_W  flattened write data
// - req_strb   in   NUM_REQ*DATA_W/8 flattened byte strobes
// - req_prot   in   NUM_REQ*3       flattened pprot
// - rsp_valid  out  NUM_REQ         one-cycle completion pulse to the granted requester
// - rsp_rdata  out  DATA_W          read data, valid with rsp_valid (shared bus)
// - rsp_err    out  1               pslverr (or timeout) for the completing transfer
// - psel, penable, pwrite  out 1    APB control
// - paddr out ADDR_W; pwdata out DATA_W; pstrb out DATA_W/8; pprot out 3
// - prdata in DATA_W; pready in 1; pslverr in 1
// BEHAVIOUR
// - FSM IDLE -> SETUP -> ACCESS. IDLE: any req_valid -> arbitrate, latch winner fields, go SETUP.
// - SETUP (1 cycle): psel=1, penable=0, req_ready[winner]=1; always -> ACCESS.
// - ACCESS: psel=1, penable=1; hold until pready=1. On pready: rsp_valid[winner]=1,
//   rsp_rdata=prdata (0 for writes), rsp_err=pslverr; if any req_valid, re-arbitrate -> SETUP
//   (back-to-back, psel stays 1); else -> IDLE.
// - Latency: req_valid seen in IDLE at cycle 0 -> SETUP cycle 1 -> earliest rsp_valid in cycle 2.
// - Round-robin: search starts at ptr; ptr <= winner+1 (mod NUM_REQ) on each grant.
// - Arbitration occurs only in IDLE or on the pready cycle; req_valid changes elsewhere are ignored.
// - Address/data/strb/prot/pwrite registered at grant; stable through SETUP and ACCESS.
// - Reads drive pstrb=0; writes drive the requester strb unchanged.
// - Requester dropping req_valid before req_ready: request withdrawn, no transfer.
// - pready high in the SETUP cycle is ignored (sampled only in ACCESS).
// - Reset (async, any state): FSM IDLE, ptr=0, every output 0 (psel, penable, pwrite, paddr,
//   pwdata, pstrb, pprot, req_ready, rsp_valid, rsp_rdata, rsp_err). A transfer in flight is abandoned.
// CONFIGURATION
// - APB_ARB_TIMEOUT_EN defined: counter cleared on entering ACCESS, increments while pready=0;
//   on reaching TIMEOUT_CYC, complete with rsp_valid=1, rsp_err=1, rsp_rdata=0, deassert psel -> IDLE.
// - Undefined: no counter; ACCESS waits for pready indefinitely; TIMEOUT_CYC unused.
// STRUCTURE
// - apb_arb_pkg: state_t enum {IDLE,SETUP,ACCESS}, APB_PROT_W=3, default width constants.
// - Sub-module apb_rr_arbiter: NUM_REQ-wide round-robin pick (req vector, ptr, en -> one-hot
//   grant, index, ptr update). The FSM and datapath stay in apb_master_arbiter.
// TESTING
// - Single write, req0 addr 0x10 data 0xA5A5_0001 strb 0xF, pready=1 -> SETUP c1, ACCESS c2, rsp_valid[0] c2, rsp_err=0.
// - Read req2 addr 0x20, pready low 3 ACCESS cycles, prdata=0x1234 -> rsp_rdata=0x1234, pstrb=0 throughout.
// - All 4 req_valid held high -> grants 0,1,2,3,0 in order, psel never drops between transfers.
// - pslverr=1 on write -> rsp_err=1 with rsp_valid; next transfer has rsp_err=0.
// - preset_n low mid-ACCESS -> psel, penable, rsp_valid 0 immediately; after release, ptr=0, req0 wins.
// - APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, pready stuck 0 -> rsp_err=1, rsp_rdata=0 after 8 ACCESS cycles, FSM IDLE.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam int unsigned APB_PROT_W      = 3;
   localparam int unsigned DEF_NUM_REQ     = 4;
   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_TIMEOUT_CYC = 256;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick over NUM_REQ requesters; search starts at i_ptr, returns one-hot
// grant, winner index and the pointer value to use after this grant.
module apb_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   input  logic                       i_en,
   output logic                       o_valid,
   output logic [NUM_REQ-1:0]         o_gnt,
   output logic [$clog2(NUM_REQ)-1:0] o_idx,
   output logic [$clog2(NUM_REQ)-1:0] o_ptr_nxt
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
      return IDX_W'(v % NUM_REQ);
   endfunction

   always_comb begin
      o_valid = 1'b0;
      o_gnt   = '0;
      o_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (i_en && !o_valid && i_req[wrap_idx(32'(i_ptr) + k)]) begin
            o_valid = 1'b1;
            o_idx   = wrap_idx(32'(i_ptr) + k);
         end
      end
      if (o_valid) begin
         o_gnt[o_idx] = 1'b1;
      end
      o_ptr_nxt = wrap_idx(32'(o_idx) + 1);
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB4 master port among NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                             pclk,
   input  logic                             preset_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]        req_wdata,
   input  logic [NUM_REQ*DATA_W/8-1:0]      req_strb,
   input  logic [NUM_REQ*APB_PROT_W-1:0]    req_prot,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_W-1:0]                rsp_rdata,
   output logic                             rsp_err,
   output logic                             psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [ADDR_W-1:0]                paddr,
   output logic [DATA_W-1:0]                pwdata,
   output logic [DATA_W/8-1:0]              pstrb,
   output logic [APB_PROT_W-1:0]            pprot,
   input  logic [DATA_W-1:0]                prdata,
   input  logic                             pready,
   input  logic                             pslverr
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned IDX_W  = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_err
      $error("apb_master_arbiter: unsupported parameter values");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_ptr;
   logic [NUM_REQ-1:0]    r_gnt;
   logic                  r_write;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [STRB_W-1:0]     r_strb;
   logic [APB_PROT_W-1:0] r_prot;

   logic                  w_arb_en;
   logic                  w_arb_valid;
   logic [NUM_REQ-1:0]    w_arb_gnt;
   logic [IDX_W-1:0]      w_arb_idx;
   logic [IDX_W-1:0]      w_ptr_nxt;
   logic                  w_done;
   logic                  w_timeout;

   // Arbitration only happens while idle or on the cycle the current transfer completes.
   assign w_arb_en = (r_state == IDLE) || ((r_state == ACCESS) && pready);
   assign w_done   = (r_state == ACCESS) && pready;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .i_req     (req_valid),
      .i_ptr     (r_ptr),
      .i_en      (w_arb_en),
      .o_valid   (w_arb_valid),
      .o_gnt     (w_arb_gnt),
      .o_idx     (w_arb_idx),
      .o_ptr_nxt (w_ptr_nxt)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_cnt <= '0;
      end else if (r_state != ACCESS) begin
         r_cnt <= '0;
      end else if (!pready) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_timeout = (r_state == ACCESS) && !pready && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               w_state_nxt = w_arb_valid ? SETUP : IDLE;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_prot  <= '0;
      end else if (w_arb_valid) begin
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_arb_gnt;
         r_write <= req_write[w_arb_idx];
         r_addr  <= req_addr[32'(w_arb_idx) * ADDR_W +: ADDR_W];
         r_wdata <= req_wdata[32'(w_arb_idx) * DATA_W +: DATA_W];
         // Reads present an all-zero strobe on the bus.
         r_strb  <= req_write[w_arb_idx] ? req_strb[32'(w_arb_idx) * STRB_W +: STRB_W] : '0;
         r_prot  <= req_prot[32'(w_arb_idx) * APB_PROT_W +: APB_PROT_W];
      end
   end

   assign psel      = (r_state != IDLE);
   assign penable   = (r_state == ACCESS);
   assign pwrite    = r_write;
   assign paddr     = r_addr;
   assign pwdata    = r_wdata;
   assign pstrb     = r_strb;
   assign pprot     = r_prot;
   assign req_ready = (r_state == SETUP) ? r_gnt : '0;
   assign rsp_valid = (w_done || w_timeout) ? r_gnt : '0;
   assign rsp_rdata = (w_done && !r_write) ? prdata : '0;
   assign rsp_err   = w_done ? pslverr : w_timeout;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a transaction-level reference model.
// Define APB_ARB_TIMEOUT_EN for both bench and RTL to exercise the timeout case.
module tb_apb_master_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 8;

   logic            pclk = 1'b0;
   logic            preset_n;
   logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_strb;
   logic [N*3-1:0]  req_prot;
   logic [DW-1:0]   rsp_rdata, pwdata, prdata;
   logic            rsp_err, psel, penable, pwrite, pready, pslverr;
   logic [AW-1:0]   paddr;
   logic [SW-1:0]   pstrb;
   logic [2:0]      pprot;

   apb_master_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
   ) dut (
      .pclk(pclk), .preset_n(preset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic keep  = 1'b0;

   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int            idx;
      logic [DW-1:0] rdata;
      logic          err;
      int            c;
   } rsp_t;

   int   grants[$];
   int   gcyc[$];
   rsp_t rsps[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int low_idx(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[k]) return k;
      end
      return -1;
   endfunction

   // Reference model: phase 0 idle, 1 setup, 2 access.
   int            m_phase = 0;
   int            m_ptr   = 0;
   int            m_win   = 0;
   int            m_wait  = 0;
   logic          m_wr    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [SW-1:0] m_strb  = '0;
   logic [2:0]    m_prot  = '0;

   always @(negedge pclk) begin
      logic [N-1:0]  e_rdy, e_rv;
      logic [DW-1:0] e_rd;
      logic          e_err, done, to, arb;
      int            pick;
      if (!preset_n) begin
         m_phase = 0;
         m_ptr   = 0;
         chk("rst_psel", psel, 0);
         chk("rst_penable", penable, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_paddr", paddr, 0);
         chk("rst_pwdata", pwdata, 0);
         chk("rst_pstrb", pstrb, 0);
         chk("rst_pprot", pprot, 0);
         chk("rst_pwrite", pwrite, 0);
      end else begin
         done = (m_phase == 2) && pready;
         to   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         to   = (m_phase == 2) && !pready && (m_wait + 1 == TO);
`endif
         e_rdy = (m_phase == 1) ? N'(1 << m_win) : '0;
         e_rv  = (done || to) ? N'(1 << m_win) : '0;
         e_rd  = (done && !m_wr) ? prdata : '0;
         e_err = done ? pslverr : to;
         chk("psel", psel, m_phase != 0);
         chk("penable", penable, m_phase == 2);
         chk("req_ready", req_ready, e_rdy);
         chk("rsp_valid", rsp_valid, e_rv);
         chk("rsp_rdata", rsp_rdata, e_rd);
         chk("rsp_err", rsp_err, e_err);
         if (m_phase != 0) begin
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_wr);
            chk("pprot", pprot, m_prot);
            chk("pstrb", pstrb, m_wr ? m_strb : '0);
            if (m_wr) chk("pwdata", pwdata, m_wdata);
         end
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               grants.push_back(i);
               gcyc.push_back(cyc);
            end
         end
         if (rsp_valid != '0) begin
            rsps.push_back('{idx: low_idx(rsp_valid), rdata: rsp_rdata, err: rsp_err, c: cyc});
         end
         arb = (m_phase == 0) || done;
         if (arb) begin
            pick = rr_pick(req_valid, m_ptr);
            if (pick >= 0) begin
               m_win   = pick;
               m_ptr   = (pick + 1) % N;
               m_wr    = req_write[pick];
               m_addr  = req_addr[pick*AW +: AW];
               m_wdata = req_wdata[pick*DW +: DW];
               m_strb  = req_strb[pick*SW +: SW];
               m_prot  = req_prot[pick*3 +: 3];
               m_phase = 1;
            end else begin
               m_phase = 0;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
            m_wait  = 0;
         end else if (to) begin
            m_phase = 0;
         end else begin
            m_wait++;
         end
      end
   end

   // One clock; a requester drops its valid after the edge that saw its req_ready.
   task automatic tick();
      logic [N-1:0] rdy;
      @(negedge pclk);
      rdy = req_ready;
      @(posedge pclk);
      #1;
      if (!keep) req_valid = req_valid & ~rdy;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
      req_write[i]          = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_strb[i*SW +: SW]  = s;
      req_prot[i*3 +: 3]    = p;
      req_valid[i]          = 1'b1;
   endtask

   task automatic wait_rsp(input int n0, input int budget, input string name);
      int k = 0;
      while (rsps.size() <= n0 && k < budget) begin
         tick();
         k++;
      end
      chk(name, rsps.size(), n0 + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0, g0, c0, k, drops;
      preset_n  = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      req_prot  = '0;
      prdata    = '0;
      pready    = 1'b1;
      pslverr   = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      preset_n = 1'b1;

      // Single write from requester 0.
      n0 = rsps.size(); g0 = grants.size(); c0 = cyc;
      set_req(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b000);
      wait_rsp(n0, 20, "t1_completes");
      if (rsps.size() > n0 && grants.size() > g0) begin
         chk("t1_grant_idx", grants[g0], 0);
         chk("t1_setup_cyc", gcyc[g0] - c0, 1);
         chk("t1_rsp_cyc", rsps[n0].c - c0, 2);
         chk("t1_rsp_idx", rsps[n0].idx, 0);
         chk("t1_rsp_err", rsps[n0].err, 0);
      end

      // Read from requester 2 with three wait states; a stray request is ignored meanwhile.
      n0 = rsps.size(); g0 = grants.size();
      pready = 1'b0;
      set_req(2, 1'b0, 32'h20, 32'h0, 4'hF, 3'b010);
      c0 = cyc;
      tick();
      tick();
      chk("t2_penable", penable, 1);
      chk("t2_pstrb_read", pstrb, 0);
      set_req(0, 1'b1, 32'h99, 32'h99, 4'hF, 3'b000);
      tick();
      req_valid[0] = 1'b0;
      tick();
      tick();
      pready = 1'b1;
      prdata = 32'h1234;
      wait_rsp(n0, 10, "t2_completes");
      prdata = '0;
      if (rsps.size() > n0) begin
         chk("t2_rsp_idx", rsps[n0].idx, 2);
         chk("t2_rsp_rdata", rsps[n0].rdata, 32'h1234);
         chk("t2_rsp_cyc", rsps[n0].c - c0, 5);
      end
      chk("t2_stray_ignored", grants.size() - g0, 1);

      // Slave error on a write, then a clean read.
      n0 = rsps.size();
      pslverr = 1'b1;
      prdata  = 32'h5555;
      set_req(1, 1'b1, 32'h30, 32'hDEAD_BEEF, 4'h3, 3'b001);
      wait_rsp(n0, 20, "t4a_completes");
      pslverr = 1'b0;
      prdata  = 32'hBEEF;
      set_req(3, 1'b0, 32'h40, 32'h0, 4'hC, 3'b100);
      wait_rsp(n0 + 1, 20, "t4b_completes");
      prdata = '0;
      if (rsps.size() > n0 + 1) begin
         chk("t4_err_idx", rsps[n0].idx, 1);
         chk("t4_err_flag", rsps[n0].err, 1);
         chk("t4_write_rdata", rsps[n0].rdata, 0);
         chk("t4_next_idx", rsps[n0+1].idx, 3);
         chk("t4_next_err", rsps[n0+1].err, 0);
         chk("t4_next_rdata", rsps[n0+1].rdata, 32'hBEEF);
      end

      // Asynchronous reset while a transfer is completing.
      pready = 1'b0;
      set_req(0, 1'b1, 32'h50, 32'h77, 4'hF, 3'b000);
      tick();
      tick();
      pready = 1'b1;
      #1;
      chk("t5_pre_rsp_valid", rsp_valid, 4'b0001);
      preset_n = 1'b0;
      #1;
      chk("t5_rst_psel", psel, 0);
      chk("t5_rst_penable", penable, 0);
      chk("t5_rst_rsp_valid", rsp_valid, 0);
      req_valid = '0;
      tick();
      tick();
      preset_n = 1'b1;

      // All requesters held high: strict rotation from 0, bus never idles.
      g0 = grants.size();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i * 4), 32'(i), 4'hF, 3'(i));
      keep  = 1'b1;
      drops = 0;
      k     = 0;
      while (grants.size() - g0 < 5 && k < 60) begin
         tick();
         k++;
         if (grants.size() - g0 >= 1 && grants.size() - g0 < 5 && !psel) drops++;
      end
      req_valid = '0;
      keep      = 1'b0;
      chk("t3_grant_count", grants.size() - g0, 5);
      if (grants.size() - g0 >= 5) begin
         chk("t3_grant0", grants[g0],   0);
         chk("t3_grant1", grants[g0+1], 1);
         chk("t3_grant2", grants[g0+2], 2);
         chk("t3_grant3", grants[g0+3], 3);
         chk("t3_grant4", grants[g0+4], 0);
      end
      chk("t3_psel_drops", drops, 0);
      repeat (3) tick();
      chk("t3_idle_after", psel, 0);

`ifdef APB_ARB_TIMEOUT_EN
      // Slave never responds: timeout completes with an error.
      n0 = rsps.size(); g0 = grants.size();
      pready = 1'b0;
      prdata = 32'hFFFF;
      set_req(1, 1'b0, 32'h60, 32'h0, 4'hF, 3'b000);
      wait_rsp(n0, 30, "t6_completes");
      if (rsps.size() > n0 && grants.size() > g0) begin
         chk("t6_err", rsps[n0].err, 1);
         chk("t6_rdata", rsps[n0].rdata, 0);
         chk("t6_wait_cycles", rsps[n0].c - gcyc[g0], TO);
      end
      chk("t6_idle_psel", psel, 0);
      pready = 1'b1;
      prdata = '0;
      repeat (2) tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
